// File: rtl/gigatron_video_capture.sv
// Gigatron video capture: turns the CPU's OUT port (sync + BBGGRR) into pixel strobes with x/y.
// Optional build macro GIGATRON_VIDEO_STATS_EN adds frame and error counters.
module gigatron_video_capture #(
    parameter int unsigned H_BP     = 16,
    parameter int unsigned H_ACTIVE = 160,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [7:0]  i_out,
    output logic        o_valid,
    output logic [5:0]  o_pixel,
    output logic [7:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_frame_done,
    output logic        o_err
`ifdef GIGATRON_VIDEO_STATS_EN
    ,
    output logic [15:0] o_frame_count,
    output logic [7:0]  o_err_count
`endif
);

    localparam int unsigned CNT_MAX    = (H_BP > V_BP) ? H_BP : V_BP;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic        SKIP_PORCH = (H_BP == 1);

    typedef enum logic [2:0] {
        WAIT_VSYNC,
        V_PORCH,
        H_PORCH,
        ACTIVE,
        H_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_out;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [7:0]         r_x;
    logic [7:0]         w_x_nxt;
    logic [8:0]         r_y;
    logic [8:0]         w_y_nxt;
    logic               w_valid_nxt;
    logic [5:0]         w_pixel_nxt;
    logic [7:0]         w_ox_nxt;
    logic [8:0]         w_oy_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic               w_line_end;
    logic               w_start_line;
    logic               w_vs_rise;
    logic               w_hs_rise;

    assign w_vs_rise = ~r_out[7] & i_out[7];
    assign w_hs_rise = ~r_out[6] & i_out[6];

    // State, counters and registered outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= WAIT_VSYNC;
            r_out        <= 8'hFF;
            r_cnt        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            o_valid      <= 1'b0;
            o_pixel      <= '0;
            o_x          <= '0;
            o_y          <= '0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_out        <= i_out;
            r_cnt        <= w_cnt_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            o_valid      <= w_valid_nxt;
            o_pixel      <= w_pixel_nxt;
            o_x          <= w_ox_nxt;
            o_y          <= w_oy_nxt;
            o_frame_done <= w_done_nxt;
            o_err        <= w_err_nxt;
        end
    end

    // Next-state logic; a vsync edge outranks any hsync edge in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_valid_nxt  = 1'b0;
        w_pixel_nxt  = o_pixel;
        w_ox_nxt     = o_x;
        w_oy_nxt     = o_y;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_line_end   = 1'b0;
        w_start_line = 1'b0;

        if (w_vs_rise) begin
            w_err_nxt   = (r_state != WAIT_VSYNC);
            w_state_nxt = V_PORCH;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                V_PORCH: begin
                    if (w_hs_rise) begin
                        if (r_cnt == CNT_W'(V_BP - 1)) begin
                            w_y_nxt      = '0;
                            w_start_line = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                H_PORCH: begin
                    if (w_hs_rise) begin
                        w_err_nxt  = 1'b1;
                        w_line_end = 1'b1;
                    end else if (r_cnt == CNT_W'(H_BP - 1)) begin
                        w_state_nxt = ACTIVE;
                        w_x_nxt     = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (w_hs_rise) begin
                        w_err_nxt  = 1'b1;
                        w_line_end = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_pixel_nxt = i_out[5:0];
                        w_ox_nxt    = r_x;
                        w_oy_nxt    = r_y;
                        if (r_x == 8'(H_ACTIVE - 1)) begin
                            w_state_nxt = H_WAIT;
                        end else begin
                            w_x_nxt = r_x + 8'd1;
                        end
                    end
                end
                H_WAIT: begin
                    w_line_end = w_hs_rise;
                end
                default: ;
            endcase
        end

        // An hsync edge closes the current line, whether it was complete or truncated.
        if (w_line_end) begin
            if (r_y == 9'(V_ACTIVE - 1)) begin
                w_state_nxt = WAIT_VSYNC;
                w_done_nxt  = 1'b1;
            end else begin
                w_y_nxt      = r_y + 9'd1;
                w_start_line = 1'b1;
            end
        end

        if (w_start_line) begin
            w_x_nxt = '0;
            if (SKIP_PORCH) begin
                w_state_nxt = ACTIVE;
            end else begin
                w_state_nxt = H_PORCH;
                w_cnt_nxt   = CNT_W'(1);
            end
        end
    end

`ifdef GIGATRON_VIDEO_STATS_EN
    // Frame count wraps; error count saturates.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_frame_count <= '0;
            o_err_count   <= '0;
        end else begin
            if (w_done_nxt) begin
                o_frame_count <= o_frame_count + 16'd1;
            end
            if (w_err_nxt && (o_err_count != 8'hFF)) begin
                o_err_count <= o_err_count + 8'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_gigatron_video_capture.sv
// Bench for gigatron_video_capture: randomized sync/pixel streams checked cycle by cycle
// against an edge-list reference model. Define GIGATRON_VIDEO_STATS_EN to also check counters.
module tb_gigatron_video_capture;

    localparam int H_BP     = 4;
    localparam int H_ACTIVE = 12;
    localparam int V_BP     = 3;
    localparam int V_ACTIVE = 6;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_out;
    logic       o_valid;
    logic [5:0] o_pixel;
    logic [7:0] o_x;
    logic [8:0] o_y;
    logic       o_frame_done;
    logic       o_err;
`ifdef GIGATRON_VIDEO_STATS_EN
    logic [15:0] o_frame_count;
    logic [7:0]  o_err_count;
    logic [15:0] e_fc[$];
    logic [7:0]  e_ec[$];
`endif

    always #5 clk = ~clk;

    gigatron_video_capture #(
        .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE)
    ) dut (
        .i_clock(clk),
        .i_reset(i_reset),
        .i_out(i_out),
        .o_valid(o_valid),
        .o_pixel(o_pixel),
        .o_x(o_x),
        .o_y(o_y),
        .o_frame_done(o_frame_done),
`ifdef GIGATRON_VIDEO_STATS_EN
        .o_frame_count(o_frame_count),
        .o_err_count(o_err_count),
`endif
        .o_err(o_err)
    );

    logic [7:0]  s_out[$];
    bit          s_rst[$];
    logic [2:0]  e_ctl[$];
    logic [22:0] e_dat[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          exp_strobes = 0;
    int          exp_frames = 0;
    int          got_strobes = 0;
    int          got_frames = 0;

    task automatic push(input bit vs, input bit hs, input bit rst);
        s_out.push_back({vs, hs, 6'($urandom)});
        s_rst.push_back(rst);
    endtask

    // Hsync edge starting a line; the next push'd edge lands L cycles later.
    task automatic line(input int L);
        push(1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b1, 1'b0);
        repeat (L - 2) push(1'b1, 1'b1, 1'b0);
    endtask

    task automatic vs_pulse(input bit both);
        repeat (2) push(1'b0, !both, 1'b0);
        push(1'b1, 1'b1, 1'b0);
    endtask

    task automatic frame(input int short_y, input int short_d, input int vs_y, input int vs_d,
                         input int rst_y, input int rst_d, input bit both);
        vs_pulse(both);
        for (int p = 0; p < V_BP - 1; p++) line(2 + int'($urandom_range(0, 4)));
        for (int y = 0; y < V_ACTIVE; y++) begin
            if (y == vs_y) begin
                push(1'b1, 1'b0, 1'b0);
                push(1'b1, 1'b1, 1'b0);
                repeat (vs_d) push(1'b1, 1'b1, 1'b0);
                return;
            end
            if (y == rst_y) begin
                push(1'b1, 1'b0, 1'b0);
                push(1'b1, 1'b1, 1'b0);
                repeat (rst_d) push(1'b1, 1'b1, 1'b0);
                repeat (2) push(1'b1, 1'b1, 1'b1);
                repeat (2) line(H_BP + H_ACTIVE + 2);
                return;
            end
            if (y == short_y) line(short_d);
            else line(H_BP + H_ACTIVE + int'($urandom_range(0, 3)));
        end
        line(3);
        repeat (3) push(1'b1, 1'b1, 1'b0);
    endtask

    // Reference: interpret sync edges as frames/lines; a pixel sits at offset H_BP+x from its line's edge.
    task automatic build_expect();
        bit armed = 1'b0;
        bit line_open = 1'b0;
        int porch = 0;
        int y = 0;
        int ls = 0;
        int off;
        logic [7:0] prev, cur;
        bit vr, hr, v, e, d;
        logic [7:0] lx = '0;
        logic [8:0] ly = '0;
        logic [5:0] lp = '0;
        logic [15:0] fc = '0;
        logic [7:0]  ec = '0;
        for (int c = 0; c < s_out.size(); c++) begin
            v = 1'b0; e = 1'b0; d = 1'b0;
            cur  = s_out[c];
            prev = (c == 0 || s_rst[c-1]) ? 8'hFF : s_out[c-1];
            vr   = !prev[7] && cur[7];
            hr   = !prev[6] && cur[6];
            off  = c - ls;
            if (s_rst[c]) begin
                armed = 1'b0; line_open = 1'b0;
                lx = '0; ly = '0; lp = '0; fc = '0; ec = '0;
            end else if (vr) begin
                e = armed;
                armed = 1'b1; porch = 0; line_open = 1'b0;
            end else if (armed && hr) begin
                if (line_open) begin
                    e = (off < H_BP + H_ACTIVE);
                    if (y == V_ACTIVE - 1) begin
                        d = 1'b1; armed = 1'b0; line_open = 1'b0;
                    end else begin
                        y++; ls = c;
                    end
                end else begin
                    porch++;
                    if (porch == V_BP) begin
                        y = 0; line_open = 1'b1; ls = c;
                    end
                end
            end else if (armed && line_open && off >= H_BP && off < H_BP + H_ACTIVE) begin
                v = 1'b1; lx = 8'(off - H_BP); ly = 9'(y); lp = cur[5:0];
            end
            if (!s_rst[c]) begin
                fc = fc + 16'(d);
                if (e && ec != 8'hFF) ec = ec + 8'd1;
            end
            exp_strobes += int'(v);
            exp_frames  += int'(d);
            e_ctl.push_back({v, e, d});
            e_dat.push_back({lx, ly, lp});
`ifdef GIGATRON_VIDEO_STATS_EN
            e_fc.push_back(fc);
            e_ec.push_back(ec);
`endif
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_out   = 8'hFF;

        // Directed scenarios.
        repeat (3) push(1'b1, 1'b1, 1'b1);
        repeat (4) push(1'b1, 1'b1, 1'b0);
        repeat (3) line(H_BP + H_ACTIVE + 1);
        frame(-1, 0, -1, 0, -1, 0, 1'b0);
        frame(-1, 0, -1, 0, -1, 0, 1'b1);
        frame(2, 2 + int'($urandom_range(0, H_BP + H_ACTIVE - 3)), -1, 0, -1, 0, 1'b0);
        frame(1, H_BP, -1, 0, -1, 0, 1'b0);
        frame(3, H_BP + H_ACTIVE - 1, -1, 0, -1, 0, 1'b0);
        frame(V_ACTIVE - 1, H_BP + 5, -1, 0, -1, 0, 1'b0);
        frame(-1, 0, 3, H_BP + 6, -1, 0, 1'b0);
        frame(-1, 0, -1, 0, -1, 0, 1'b0);
        frame(-1, 0, -1, 0, 4, H_BP + 3, 1'b0);
        frame(-1, 0, -1, 0, -1, 0, 1'b0);
        // Randomized frames.
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0: frame(-1, 0, -1, 0, -1, 0, 1'($urandom));
                1: frame(int'($urandom_range(0, V_ACTIVE - 1)),
                         2 + int'($urandom_range(0, H_BP + H_ACTIVE - 3)), -1, 0, -1, 0, 1'b0);
                2: frame(-1, 0, int'($urandom_range(0, V_ACTIVE - 1)),
                         int'($urandom_range(0, H_BP + H_ACTIVE)), -1, 0, 1'b0);
                default: frame(-1, 0, -1, 0, int'($urandom_range(0, V_ACTIVE - 1)),
                               int'($urandom_range(0, H_BP + H_ACTIVE)), 1'b0);
            endcase
        end
`ifdef GIGATRON_VIDEO_STATS_EN
        repeat (3) push(1'b1, 1'b1, 1'b1);
        vs_pulse(1'b0);
        repeat (300) vs_pulse(1'b0);
        repeat (3) frame(-1, 0, -1, 0, -1, 0, 1'b0);
`endif
        frame(-1, 0, -1, 0, -1, 0, 1'b0);

        build_expect();

        for (int c = 0; c < s_out.size(); c++) begin
            i_reset = s_rst[c];
            i_out   = s_out[c];
            @(posedge clk);
            #1;
            got_strobes += int'(o_valid);
            got_frames  += int'(o_frame_done);
            n_cmp++;
            assert ({o_valid, o_err, o_frame_done} === e_ctl[c]) else begin
                n_fail++;
                $error("FAIL ctl cyc=%0d valid/err/done observed=%b expected=%b",
                       c, {o_valid, o_err, o_frame_done}, e_ctl[c]);
            end
            n_cmp++;
            assert ({o_x, o_y, o_pixel} === e_dat[c]) else begin
                n_fail++;
                $error("FAIL data cyc=%0d x/y/pix observed=%0d/%0d/%h expected=%0d/%0d/%h",
                       c, o_x, o_y, o_pixel, e_dat[c][22:15], e_dat[c][14:6], e_dat[c][5:0]);
            end
`ifdef GIGATRON_VIDEO_STATS_EN
            n_cmp++;
            assert ({o_frame_count, o_err_count} === {e_fc[c], e_ec[c]}) else begin
                n_fail++;
                $error("FAIL stats cyc=%0d frames/errs observed=%0d/%0d expected=%0d/%0d",
                       c, o_frame_count, o_err_count, e_fc[c], e_ec[c]);
            end
`endif
        end

        n_cmp++;
        assert (got_strobes === exp_strobes) else begin
            n_fail++;
            $error("FAIL strobe_total observed=%0d expected=%0d", got_strobes, exp_strobes);
        end
        n_cmp++;
        assert (got_frames === exp_frames) else begin
            n_fail++;
            $error("FAIL frame_total observed=%0d expected=%0d", got_frames, exp_frames);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
